// File: rtl/cpu_display_ctrl.sv
// cpu_display_ctrl: debounced single-step button plus a 4-digit multiplexed
// 7-segment viewer showing a snapshot of CPU observation buses.
module cpu_display_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  page,
  input  logic [31:0] IF_InsAddr,
  input  logic [31:0] IF_nextPC,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [31:0] EXE_updateDataA,
  input  logic [31:0] EXE_updateDataB,
  input  logic [31:0] EXE_ALUData,
  input  logic [31:0] WB_DBData,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd3;

  logic              sync1, btn_s;
  logic [1:0]        state;
  logic [DEB_W-1:0]  deb_cnt;
  logic              step_d1, step_d2;
  logic [7:0]        snap_ins, snap_npc, snap_da, snap_db, snap_alu, snap_wb;
  logic [4:0]        snap_rs, snap_rt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig;
  logic [15:0]       disp_word;
  logic [3:0]        nibble;
  logic [6:0]        glyph;

  // Only the low byte of each 32-bit bus is ever displayed.
  logic unused_bits;
  assign unused_bits = ^{IF_InsAddr[31:8], IF_nextPC[31:8], EXE_updateDataA[31:8],
                         EXE_updateDataB[31:8], EXE_ALUData[31:8], WB_DBData[31:8]};

  // Two-flop synchroniser for the raw push button.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_step;
      btn_s <= sync1;
    end
  end

  // Debounce FSM: qualify press and release, counter cleared on each state change.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      deb_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (btn_s) begin
            state   <= S_WAIT_PRESS;
            deb_cnt <= '0;
          end
        end
        S_WAIT_PRESS: begin
          if (!btn_s) begin
            state   <= S_IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= S_PRESSED;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          state   <= S_WAIT_RELEASE;
          deb_cnt <= '0;
        end
        default: begin
          if (btn_s) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= S_IDLE;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign step_pulse = (state == S_PRESSED);

  // Delay the step strobe two cycles so the CPU outputs settle before capture.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      step_d1 <= 1'b0;
      step_d2 <= 1'b0;
    end else begin
      step_d1 <= step_pulse;
      step_d2 <= step_d1;
    end
  end

  // Snapshot of the observation buses, held until the next capture.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      snap_ins <= '0;
      snap_npc <= '0;
      snap_rs  <= '0;
      snap_rt  <= '0;
      snap_da  <= '0;
      snap_db  <= '0;
      snap_alu <= '0;
      snap_wb  <= '0;
    end else if (step_d2) begin
      snap_ins <= IF_InsAddr[7:0];
      snap_npc <= IF_nextPC[7:0];
      snap_rs  <= ID_rs;
      snap_rt  <= ID_rt;
      snap_da  <= EXE_updateDataA[7:0];
      snap_db  <= EXE_updateDataB[7:0];
      snap_alu <= EXE_ALUData[7:0];
      snap_wb  <= WB_DBData[7:0];
    end
  end

  // Page select and nibble pick for the currently scanned digit.
  always_comb begin
    disp_word = '0;
    case (page)
      2'b00:   disp_word = {snap_ins, snap_npc};
      2'b01:   disp_word = {3'b000, snap_rs, snap_da};
      2'b10:   disp_word = {3'b000, snap_rt, snap_db};
      default: disp_word = {snap_alu, snap_wb};
    endcase
    nibble = '0;
    case (dig)
      2'd3:    nibble = disp_word[15:12];
      2'd2:    nibble = disp_word[11:8];
      2'd1:    nibble = disp_word[7:4];
      default: nibble = disp_word[3:0];
    endcase
  end

  // Hex glyph decode, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    glyph = '1;
    case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  end

  // Scan timer: each digit is held for SCAN_DIV cycles.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig      <= dig + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Registered digit enable and segment outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= ~(4'b0001 << dig);
      seg <= {1'b1, glyph};
    end
  end

endmodule

// File: tb/tb_cpu_display_ctrl.sv
// Testbench for cpu_display_ctrl: directed scenarios plus random button and
// bus activity, checked per cycle through an expectation queue.
module tb_cpu_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic        CLK = 1'b0;
  logic        Reset, btn_step;
  logic [1:0]  page;
  logic [31:0] ins, npc, da, db, alu, wb;
  logic [4:0]  rs, rt;
  logic        step_pulse;
  logic [3:0]  an;
  logic [7:0]  seg;

  cpu_display_ctrl #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .Reset(Reset), .btn_step(btn_step), .page(page),
    .IF_InsAddr(ins), .IF_nextPC(npc), .ID_rs(rs), .ID_rt(rt),
    .EXE_updateDataA(da), .EXE_updateDataB(db), .EXE_ALUData(alu),
    .WB_DBData(wb), .step_pulse(step_pulse), .an(an), .seg(seg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [3:0] an;
    logic [7:0] seg;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   dut_pulses = 0;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: time since reset, button history, press/release
  // run lengths, pending capture time, snapshot bytes.
  int         pk = 0;
  int         n_since;
  logic       h1, h2;
  bit         armed, skip;
  int         run_hi, run_lo, cap_at;
  logic [7:0] s_ins, s_npc, s_da, s_db, s_alu, s_wb;
  logic [4:0] s_rs, s_rt;

  task automatic model_reset();
    n_since = 0; h1 = 0; h2 = 0;
    armed = 1; skip = 0; run_hi = 0; run_lo = 0; cap_at = -1;
    s_ins = 0; s_npc = 0; s_da = 0; s_db = 0; s_alu = 0; s_wb = 0; s_rs = 0; s_rt = 0;
  endtask

  task automatic model_step();
    exp_t       e;
    logic [15:0] w;
    int         d;
    logic       b;
    pk++;
    e.id = pk;
    e.pulse = 1'b0;
    if (Reset) begin
      e.an = 4'hF; e.seg = 8'hFF;
      exp_q.push_back(e);
      model_reset();
      return;
    end
    n_since++;
    d = ((n_since - 1) / SCAN_DIV) % 4;
    e.an = ~(4'(1) << d);
    case (page)
      2'd0: w = {s_ins, s_npc};
      2'd1: w = {3'b000, s_rs, s_da};
      2'd2: w = {3'b000, s_rt, s_db};
      default: w = {s_alu, s_wb};
    endcase
    e.seg = glyph_tab[(w >> (4 * d)) & 16'hF];
    b = h2; h2 = h1; h1 = btn_step;
    if (armed) begin
      run_hi = b ? run_hi + 1 : 0;
      if (run_hi == DEB + 1) begin
        e.pulse = 1'b1; armed = 0; skip = 1; run_lo = 0; cap_at = pk + 3;
      end
    end else if (skip) begin
      skip = 0;
    end else begin
      run_lo = b ? 0 : run_lo + 1;
      if (run_lo == DEB) begin
        armed = 1; run_hi = 0;
      end
    end
    if (pk == cap_at) begin
      s_ins = ins[7:0]; s_npc = npc[7:0]; s_da = da[7:0]; s_db = db[7:0];
      s_alu = alu[7:0]; s_wb = wb[7:0]; s_rs = rs; s_rt = rt;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic b, input logic r);
    @(negedge CLK);
    #1;
    btn_step = b;
    Reset = r;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Wait for each digit in turn and compare its segments.
  task automatic check_digits(input string name, input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
    logic [7:0] req [4];
    req[0] = s0; req[1] = s1; req[2] = s2; req[3] = s3;
    for (int d = 0; d < 4; d++) begin
      int t = 0;
      while (an !== ~(4'(1) << d) && t < 8 * SCAN_DIV) begin
        tick(btn_step, 1'b0);
        t++;
      end
      checks++;
      if (an !== ~(4'(1) << d)) begin
        errors++;
        $display("FAIL %s digit %0d: an=%b never selected it", name, d, an);
      end else if (seg !== req[d]) begin
        errors++;
        $display("FAIL %s digit %0d: seg=%h required %h", name, d, seg, req[d]);
      end
    end
  endtask

  // Monitor: every cycle the display presents a value; compare with the queue.
  always @(negedge CLK) begin
    if (step_pulse === 1'b1) dut_pulses++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (an !== mon_e.an || seg !== mon_e.seg) begin
        errors++;
        $display("FAIL display cyc=%0d: an=%b seg=%h required an=%b seg=%h",
                 mon_e.id, an, seg, mon_e.an, mon_e.seg);
      end
      checks++;
      if (step_pulse !== mon_e.pulse) begin
        errors++;
        $display("FAIL step_pulse cyc=%0d: got %b required %b", mon_e.id, step_pulse, mon_e.pulse);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [3:0] scan_seq [17] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                                4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'hE};

  initial begin
    int p0;
    Reset = 1; btn_step = 0; page = 0;
    ins = 0; npc = 0; da = 0; db = 0; alu = 0; wb = 0; rs = 0; rt = 0;
    model_reset();

    repeat (3) tick(0, 1);
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset: an=%b seg=%h required 1111 ff", an, seg);
    end

    // Scan order straight out of reset.
    for (int i = 0; i < 17; i++) begin
      tick(0, 0);
      check_val($sformatf("scan_an[%0d]", i), int'(an), int'(scan_seq[i]));
    end

    // Clean press, then show the captured PC bytes.
    ins = 32'h0000_0014; npc = 32'h0000_0018; page = 2'b00;
    p0 = dut_pulses;
    repeat (10) tick(1, 0);
    repeat (8) tick(0, 0);
    check_val("clean_press_pulses", dut_pulses - p0, 1);
    check_digits("capture", 8'hF9, 8'h99, 8'hF9, 8'h80);

    // Bounce then stable press.
    p0 = dut_pulses;
    tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    repeat (8) tick(1, 0);
    repeat (8) tick(0, 0);
    check_val("bounce_pulses", dut_pulses - p0, 1);

    // Page switch on a held snapshot.
    rt = 5'd31; db = 32'h0000_00AB; page = 2'b01;
    repeat (6) tick(1, 0);
    repeat (8) tick(0, 0);
    rt = 5'd2; db = 32'h0000_0033;
    page = 2'b10;
    check_digits("page_switch", 8'hF9, 8'h8E, 8'h88, 8'h83);

    // Reset while the press is being qualified.
    p0 = dut_pulses;
    repeat (4) tick(1, 0);
    check_val("pre_reset_pulses", dut_pulses - p0, 0);
    repeat (2) tick(1, 1);
    check_val("reset_an", int'(an), 15);
    check_val("reset_seg", int'(seg), 255);
    repeat (8) tick(1, 0);
    repeat (8) tick(0, 0);
    check_val("post_reset_pulses", dut_pulses - p0, 1);

    // Random button activity, page flips, bus changes and occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic b;
      int len;
      b = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 7) == 0) page = 2'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          ins = $urandom; npc = $urandom; da = $urandom; db = $urandom;
          alu = $urandom; wb = $urandom; rs = 5'($urandom); rt = 5'($urandom);
        end
        tick(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end

    repeat (4) tick(0, 0);
    @(negedge CLK);
    #1;
    check_val("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_display_ctrl.md
CPU_DISPLAY_CTRL -- requirements
Module: cpu_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, setting the number of CLK cycles each 7-segment digit is driven.
REQ-002 SHALL have parameter DEB_CYCLES, default 500000, setting the number of stable samples required to accept a button edge.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn_step, input, 1 bit: raw, unsynchronised single-step push button.
REQ-006 SHALL have port page, input, 2 bits: display page select switches.
REQ-007 SHALL have ports IF_InsAddr, IF_nextPC, EXE_updateDataA, EXE_updateDataB, EXE_ALUData and WB_DBData, each input, 32 bits: CPU observation buses.
REQ-008 SHALL have ports ID_rs and ID_rt, each input, 5 bits: CPU register indices.
REQ-009 SHALL have port step_pulse, output, 1 bit: one-cycle strobe that advances the CPU by one clock.
REQ-010 SHALL have port an, output, 4 bits: active-low digit enables; an[3] is the leftmost digit.
REQ-011 SHALL have port seg, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-012 SHALL pass btn_step through a 2-flop synchroniser; only the synchronised value, btn_s, feeds the debounce FSM.
REQ-013 SHALL implement the debounce FSM as follows; counter deb_cnt clears on every state change:
- IDLE -> WAIT_PRESS when btn_s=1.
- WAIT_PRESS -> IDLE if btn_s=0; -> PRESSED when btn_s has been 1 for DEB_CYCLES consecutive cycles.
- PRESSED -> WAIT_RELEASE unconditionally, after 1 cycle.
- WAIT_RELEASE -> IDLE after DEB_CYCLES consecutive cycles with btn_s=0; deb_cnt clears if btn_s=1.
REQ-014 SHALL assert step_pulse exactly in the cycle the FSM is in PRESSED: one pulse per accepted press, and none while the button is held.
REQ-015 SHALL capture a snapshot of all observation inputs 2 cycles after step_pulse, through a 2-stage delay of step_pulse, so the CPU outputs have settled; the snapshot holds until the next capture.
REQ-016 SHALL select display bytes from the snapshot as {L,R}, where L drives digits 3:2 and R drives digits 1:0:
- page 00: {IF_InsAddr[7:0], IF_nextPC[7:0]}
- page 01: {3'b0,ID_rs, EXE_updateDataA[7:0]}
- page 10: {3'b0,ID_rt, EXE_updateDataB[7:0]}
- page 11: {EXE_ALUData[7:0], WB_DBData[7:0]}
REQ-017 SHALL apply page changes combinationally to the snapshot, so a change is visible at the next digit slot without waiting for a step.
REQ-018 SHALL run scan counter scan_cnt from 0 to SCAN_DIV-1 and then wrap to 0; on wrap, digit index dig (2 bits) increments 3->0 wrap.
REQ-019 SHALL drive an to the one-cold value of dig, so dig=0 gives 4'b1110 and dig=3 gives 4'b0111.
REQ-020 SHALL drive seg with the standard hex glyph of the selected nibble (0-F), with dp off (1); both an and seg are registered outputs.
REQ-021 SHALL give the glyph table as seg[6:0] values: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.

Reset
REQ-022 SHALL, while Reset=1 and asynchronously, set: FSM=IDLE, deb_cnt=0, synchroniser=0, step_pulse=0, delay stages=0, snapshot=0, scan_cnt=0, dig=0, an=4'b1111, seg=8'hFF.
REQ-023 SHALL, when Reset asserts mid-debounce or mid-capture, emit no pulse and no capture; a button held through reset release must be re-qualified from IDLE.

Verification (bench uses SCAN_DIV=4, DEB_CYCLES=3)
REQ-024 SHALL check clean press: btn_step high for 10 cycles -> exactly one step_pulse, 5 cycles after the first high sample (2 sync + 3 deb); no further pulse while held.
REQ-025 SHALL check bounce: btn_step toggles 1,0,1,0 each cycle, then stays high -> no pulse during the bounce, then one pulse after 3 stable cycles.
REQ-026 SHALL check capture: IF_InsAddr=0x0000_0014, IF_nextPC=0x18, page=00, then a press -> 2 cycles after step_pulse, digits 3..0 show 1,4,1,8 (seg 1111001,0011001,1111001,0000000).
REQ-027 SHALL check scan: with no press, an cycles 1110,1101,1011,0111 in order, 4 cycles each, then wraps to 1110.
REQ-028 SHALL check page switch: snapshot ID_rt=5'd31, EXE_updateDataB=0xAB, page=10 -> digits show 1,F,A,B, with no new step required.
REQ-029 SHALL check reset mid-operation: Reset pulses while the FSM is in WAIT_PRESS -> an=1111, seg=FF, no step_pulse; after release with the button still high, one pulse follows 5 cycles later.
